// File: rtl/reg_arb_pkg.sv
// Shared types and width helpers for the register write arbiter and its picker.
package reg_arb_pkg;

  localparam int unsigned DEF_N_REQ      = 4;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_GAP_CYCLES = 0;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned GAP_W          = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Index width for a requester count; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N_REQ.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  logic [2*N_REQ-1:0] req2;
  logic [N_REQ-1:0]   rot;
  int unsigned        sum;

  // Rotate so bit 0 is the requester at ptr; the lowest set bit then wins.
  always_comb begin
    req2      = {req, req};
    rot       = N_REQ'(req2 >> ptr);
    winner    = '0;
    any_valid = 1'b0;
    sum       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = 32'(ptr) + 32'(i);
        if (sum >= N_REQ) sum = sum - N_REQ;
        winner    = IDX_W'(sum);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter driving one shared enable-gated register, one registered write at a time.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = DEF_N_REQ,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  localparam int unsigned IDX_W     = idx_w(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_gnt,
  output logic                    o_wr_en,
  output logic [DATA_W-1:0]       o_wr_data,
  output logic [IDX_W-1:0]        o_owner,
  output logic                    o_busy,
  output logic [CNT_W-1:0]        o_wr_cnt
);

  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [N_REQ-1:0]   gnt_d;
  logic               wr_en_d;
  logic [DATA_W-1:0]  wr_data_d;
  logic [IDX_W-1:0]   owner_d;
  logic               busy_d;
  logic [CNT_W-1:0]   cnt_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic [DATA_W-1:0]  pick_data;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req       (i_req),
    .ptr       (ptr_q),
    .winner    (pick),
    .any_valid (pick_valid)
  );

  // Data mux for the selected requester.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == IDX_W'(k)) pick_data = i_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    gap_d     = gap_q;
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    wr_data_d = o_wr_data;
    owner_d   = o_owner;
    busy_d    = 1'b0;
    cnt_d     = o_wr_cnt;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = WRITE;
          winner_d  = pick;
          gnt_d     = N_REQ'(1) << pick;
          wr_en_d   = 1'b1;
          wr_data_d = pick_data;
          busy_d    = 1'b1;
        end
      end
      WRITE: begin
        owner_d = winner_q;
        ptr_d   = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
        cnt_d   = o_wr_cnt + CNT_W'(1);
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d  = gap_q - GAP_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      winner_q  <= '0;
      gap_q     <= '0;
      o_gnt     <= '0;
      o_wr_en   <= 1'b0;
      o_wr_data <= '0;
      o_owner   <= '0;
      o_busy    <= 1'b0;
      o_wr_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      gap_q     <= gap_d;
      o_gnt     <= gnt_d;
      o_wr_en   <= wr_en_d;
      o_wr_data <= wr_data_d;
      o_owner   <= owner_d;
      o_busy    <= busy_d;
      o_wr_cnt  <= cnt_d;
    end
  end

endmodule
